// File: rtl/int_conv_pkg.sv
// rtl/int_conv_pkg.sv - shared op encodings, default widths and pointer type for the conversion arbiter
package int_conv_pkg;

    localparam int IN_W_DEF     = 8;
    localparam int WIDE_W_DEF   = 16;
    localparam int NARROW_W_DEF = 4;
    localparam int CNT_W_DEF    = 8;

    localparam logic [1:0] OP_SEXT  = 2'd0;
    localparam logic [1:0] OP_ZEXT  = 2'd1;
    localparam logic [1:0] OP_TRUNC = 2'd2;
    localparam logic [1:0] OP_SAT   = 2'd3;

    typedef enum logic {
        PTR_P0 = 1'b0,
        PTR_P1 = 1'b1
    } ptr_e;

endpackage

// File: rtl/int_conv_unit.sv
// rtl/int_conv_unit.sv - combinational integer width converter (sext/zext/trunc/saturate)
module int_conv_unit
    import int_conv_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int WIDE_W   = WIDE_W_DEF,
    parameter int NARROW_W = NARROW_W_DEF
) (
    input  logic [IN_W-1:0]   data_i,
    input  logic [1:0]        op_i,
    output logic [WIDE_W-1:0] result_o,
    output logic              sat_o
);

    // Clamp bounds of a signed NARROW_W value, held at operand width; MIN is the bitwise complement of MAX.
    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((2 ** (NARROW_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [IN_W-1:0] sdata;
    logic [NARROW_W-1:0]    narrow;

    assign sdata = $signed(data_i);

    always_comb begin
        result_o = '0;
        sat_o    = 1'b0;
        narrow   = data_i[NARROW_W-1:0];
        case (op_i)
            OP_SEXT:  result_o = {{(WIDE_W - IN_W){data_i[IN_W-1]}}, data_i};
            OP_ZEXT:  result_o = {{(WIDE_W - IN_W){1'b0}}, data_i};
            OP_TRUNC: result_o = {{(WIDE_W - NARROW_W){1'b0}}, data_i[NARROW_W-1:0]};
            OP_SAT: begin
                if (sdata > SAT_MAX) begin
                    narrow = SAT_MAX[NARROW_W-1:0];
                    sat_o  = 1'b1;
                end else if (sdata < SAT_MIN) begin
                    narrow = SAT_MIN[NARROW_W-1:0];
                    sat_o  = 1'b1;
                end
                result_o = {{(WIDE_W - NARROW_W){1'b0}}, narrow};
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/int_conv_arbiter.sv
// rtl/int_conv_arbiter.sv - round-robin two-requester arbiter feeding one converter and a registered output stage
module int_conv_arbiter
    import int_conv_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int WIDE_W   = WIDE_W_DEF,
    parameter int NARROW_W = NARROW_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [IN_W-1:0]   req0_data,
    input  logic [1:0]        req0_op,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [IN_W-1:0]   req1_data,
    input  logic [1:0]        req1_op,
    output logic              req1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDE_W-1:0] out_data,
    output logic              out_src,
    output logic [1:0]        out_op,
    output logic [CNT_W-1:0]  sat_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ptr_e              ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDE_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic [1:0]        out_op_q, out_op_d;
    logic [CNT_W-1:0]  sat_count_q, sat_count_d;

    logic              stage_free;
    logic              grant0, grant1, grant_any;
    logic [IN_W-1:0]   sel_data;
    logic [1:0]        sel_op;
    logic [WIDE_W-1:0] conv_result;
    logic              conv_sat;

    assign stage_free = !out_valid_q || out_ready;
    assign grant_any  = grant0 || grant1;

    // Pointer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_P0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer next state: hand priority to the other requester after every grant
    always_comb begin
        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = PTR_P1;
        end else if (grant1) begin
            ptr_d = PTR_P0;
        end
    end

    // Grant decode; rst_n gating keeps any handshake from completing while reset is held
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && stage_free) begin
            grant0 = req0_valid && (!req1_valid || (ptr_q == PTR_P0));
            grant1 = req1_valid && (!req0_valid || (ptr_q == PTR_P1));
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel_data   = grant1 ? req1_data : req0_data;
    assign sel_op     = grant1 ? req1_op : req0_op;

    int_conv_unit #(
        .IN_W     (IN_W),
        .WIDE_W   (WIDE_W),
        .NARROW_W (NARROW_W)
    ) u_conv (
        .data_i   (sel_data),
        .op_i     (sel_op),
        .result_o (conv_result),
        .sat_o    (conv_sat)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_op_d    = out_op_q;
        sat_count_d = sat_count_q;
        if (grant_any) begin
            out_valid_d = 1'b1;
            out_data_d  = conv_result;
            out_src_d   = grant1;
            out_op_d    = sel_op;
            if (conv_sat && (sat_count_q != CNT_MAX)) begin
                sat_count_d = sat_count_q + 1'b1;
            end
        end else if (stage_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_op_q    <= 2'd0;
            sat_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_op_q    <= out_op_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_op    = out_op_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_int_conv_arbiter.sv
// tb/tb_int_conv_arbiter.sv - self-checking bench: directed table, corner sequences and randomized model comparison
module tb_int_conv_arbiter;
    import int_conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic [1:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_src;
    logic [1:0]  out_op;
    logic [7:0]  sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_conv_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_op     (out_op),
        .sat_count  (sat_count)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  op;
        logic [15:0] exp_data;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion from the arithmetic definition of each op
    function automatic void ref_conv(input logic [7:0] d, input logic [1:0] op,
                                     output logic [15:0] r, output bit sat);
        int v;
        v   = (d >= 8'd128) ? int'(d) - 256 : int'(d);
        sat = 1'b0;
        r   = 16'h0;
        case (op)
            2'd0: r = 16'(v & 32'hFFFF);
            2'd1: r = {8'h00, d};
            2'd2: r = 16'(d % 8'd16);
            default: begin
                if (v > 7) begin
                    v   = 7;
                    sat = 1'b1;
                end else if (v < -8) begin
                    v   = -8;
                    sat = 1'b1;
                end
                r = 16'(v & 15);
            end
        endcase
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        req0_op    = 2'd0;
        req1_op    = 2'd0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    bit          rv[2];
    logic [7:0]  rd[2];
    logic [1:0]  ro[2];
    bit          m_valid;
    logic [15:0] m_data;
    bit          m_src;
    logic [1:0]  m_op;
    int          m_cnt;
    int          m_last;

    initial begin
        vecs[0]  = '{8'h01, OP_SEXT,  16'h0001, 0};
        vecs[1]  = '{8'h8A, OP_SEXT,  16'hFF8A, 0};
        vecs[2]  = '{8'h8A, OP_ZEXT,  16'h008A, 0};
        vecs[3]  = '{8'h8A, OP_TRUNC, 16'h000A, 0};
        vecs[4]  = '{8'hFF, OP_TRUNC, 16'h000F, 0};
        vecs[5]  = '{8'h05, OP_SAT,   16'h0005, 0};
        vecs[6]  = '{8'h7F, OP_SAT,   16'h0007, 1};
        vecs[7]  = '{8'h80, OP_SAT,   16'h0008, 2};
        vecs[8]  = '{8'hFF, OP_SAT,   16'h000F, 2};
        vecs[9]  = '{8'hF8, OP_SAT,   16'h0008, 2};
        vecs[10] = '{8'h08, OP_SAT,   16'h0007, 3};

        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_ready0_idle", req0_ready, 0);
        chk("rst_ready1_idle", req1_ready, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            req0_valid = 1'b1;
            req0_data  = vecs[i].data;
            req0_op    = vecs[i].op;
            @(negedge clk);
            chk("tbl_ready0", req0_ready, 1);
            chk("tbl_ready1", req1_ready, 0);
            @(posedge clk);
            #1 req0_valid = 1'b0;
            @(negedge clk);
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_out_data", out_data, vecs[i].exp_data);
            chk("tbl_out_src", out_src, 0);
            chk("tbl_out_op", out_op, vecs[i].op);
            chk("tbl_sat_count", sat_count, vecs[i].exp_cnt);
            @(posedge clk);
            #1;
        end

        // Both requesters continuously valid: grants must alternate starting with 0
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h11; req0_op = OP_SEXT;
        req1_valid = 1'b1; req1_data = 8'h22; req1_op = OP_ZEXT;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_ready0", req0_ready, (k % 2 == 0));
            chk("alt_ready1", req1_ready, (k % 2 == 1));
            if (k > 0) chk("alt_out_src", out_src, (k - 1) % 2);
            @(posedge clk);
            #1;
        end

        // Backpressure: held result stays stable, then drains with a same-cycle accept
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 16'h0022);
            chk("bp_out_src", out_src, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_ready0", req0_ready, 1);
        chk("bp_drain_ready1", req1_ready, 0);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_nobubble_valid", out_valid, 1);
        chk("bp_nobubble_src", out_src, 0);
        chk("bp_nobubble_data", out_data, 16'h0011);

        // Asynchronous reset with a held result and a non-zero counter
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h7F; req0_op = OP_SAT;
        repeat (5) @(posedge clk);
        #1 req0_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("ar_pre_count", sat_count, 5);
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_count", sat_count, 0);
        chk("ar_data", out_data, 0);
        chk("ar_ready0_in_reset", req0_ready, 0);
        chk("ar_ready1_in_reset", req1_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ptr_ready0", req0_ready, 1);
        chk("ar_ptr_ready1", req1_ready, 0);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;

        // Counter saturation
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h80; req0_op = OP_SAT;
        repeat (300) @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("sat_stick_255", sat_count, 255);

        // Randomized run against the reference model
        do_reset();
        m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_op = '0; m_cnt = 0; m_last = 1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rd[i] = 8'h00; ro[i] = 2'd0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit free;
            int g;
            logic [15:0] r;
            bit sat;
            @(negedge clk);
            chk("rnd_out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rnd_out_data", out_data, m_data);
                chk("rnd_out_src", out_src, m_src);
                chk("rnd_out_op", out_op, m_op);
            end
            chk("rnd_sat_count", sat_count, m_cnt);
            free = !m_valid || out_ready;
            g = -1;
            if (free) begin
                if (rv[0] && rv[1]) g = (m_last == 0) ? 1 : 0;
                else if (rv[0]) g = 0;
                else if (rv[1]) g = 1;
            end
            chk("rnd_ready0", req0_ready, (g == 0));
            chk("rnd_ready1", req1_ready, (g == 1));
            if (g >= 0) begin
                ref_conv(rd[g], ro[g], r, sat);
                m_valid = 1'b1;
                m_data  = r;
                m_src   = (g == 1);
                m_op    = ro[g];
                if (sat && m_cnt < 255) m_cnt++;
                m_last = g;
            end else if (free) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (g == i || !rv[i]) begin
                    rv[i] = ($urandom_range(0, 3) != 0);
                    rd[i] = 8'($urandom);
                    ro[i] = 2'($urandom_range(0, 3));
                end
            end
            req0_valid = rv[0]; req0_data = rd[0]; req0_op = ro[0];
            req1_valid = rv[1]; req1_data = rd[1]; req1_op = ro[1];
            out_ready  = ($urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
